// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional macro BIN_TO_BCD_SAT_EN selects 9999 instead of FFFF on overflow.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int MAX_DEC    = 9999;
  localparam int SR_W       = 14;

  // Digit pattern shown when the input does not fit in four decimal digits.
  function automatic logic [NUM_DIGITS*DIGIT_W-1:0] ovf_digits();
`ifdef BIN_TO_BCD_SAT_EN
    return 16'h9999;
`else
    return 16'hFFFF;
`endif
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: add 3 to a BCD digit of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, MSB first (double dabble).
// Overflow display pattern is chosen by macro BIN_TO_BCD_SAT_EN (see bcd_pkg).
//
// state | meaning
// IDLE  | waiting for start, result outputs held
// SHIFT | adjust scratch digits and shift one bin bit in per cycle
// LATCH | publish digits and ovf, pulse done next cycle
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       bcd0,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd3
);

  state_t                          state;
  logic [SR_W-1:0]                 sr;
  logic [NUM_DIGITS*DIGIT_W-1:0]   scratch;
  logic [NUM_DIGITS*DIGIT_W-1:0]   adj;
  logic                            scratch_ovf;
  logic [3:0]                      cnt;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .din  (scratch[g*DIGIT_W +: DIGIT_W]),
      .dout (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sr          <= '0;
      scratch     <= '0;
      scratch_ovf <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      bcd0        <= '0;
      bcd1        <= '0;
      bcd2        <= '0;
      bcd3        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr          <= SR_W'(bin);
            scratch     <= '0;
            scratch_ovf <= 1'b0;
            cnt         <= 4'(BIN_W);
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          // A thousands digit carry-out means the value has passed 9999; keep it sticky.
          scratch     <= {adj[NUM_DIGITS*DIGIT_W-2:0], sr[BIN_W-1]};
          scratch_ovf <= scratch_ovf | adj[NUM_DIGITS*DIGIT_W-1];
          sr          <= {sr[SR_W-2:0], 1'b0};
          cnt         <= cnt - 4'd1;
          if (cnt == 4'd1) state <= LATCH;
        end
        LATCH: begin
          if (scratch_ovf) {bcd3, bcd2, bcd1, bcd0} <= ovf_digits();
          else             {bcd3, bcd2, bcd1, bcd0} <= scratch;
          ovf   <= scratch_ovf;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, scoreboard and corner sequences.
// Honours BIN_TO_BCD_SAT_EN for the expected overflow digits.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] bin;
  logic        start;
  logic        busy, done, ovf;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3;

  bin_to_bcd_seq #(.BIN_W(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bin   (bin),
    .start (start),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .bcd0  (bcd0),
    .bcd1  (bcd1),
    .bcd2  (bcd2),
    .bcd3  (bcd3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d3, d2, d1, d0;
    logic       ovf;
  } exp_t;

  typedef struct {
    int   v;
    exp_t e;
  } vec_t;

`ifdef BIN_TO_BCD_SAT_EN
  localparam logic [3:0] OD = 4'h9;
`else
  localparam logic [3:0] OD = 4'hF;
`endif

  int   checks = 0;
  int   errors = 0;
  int   m_cnt  = 0;
  logic m_done = 1'b0;
  exp_t sb[$];
  exp_t exp_last = '0;

  function automatic exp_t ref_exp(int v);
    exp_t e;
    if (v > 9999) e = '{d3: OD, d2: OD, d1: OD, d0: OD, ovf: 1'b1};
    else e = '{d3: 4'(v / 1000), d2: 4'((v / 100) % 10), d1: 4'((v / 10) % 10),
               d0: 4'(v % 10), ovf: 1'b0};
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {15'd0, bcd3, bcd2, bcd1, bcd0, ovf};
  endfunction

  // Timing reference: an accepted start keeps the block busy 15 cycles, done on the 16th.
  task automatic model();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt  = 0;
        m_done = 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt--;
        m_done = (m_cnt == 0);
      end else begin
        m_done = 1'b0;
        if (start) begin
          sb.push_back(ref_exp(int'(bin)));
          m_cnt = 15;
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_last = '0;
        chk("reset_outputs", {outs()[31:1], busy, done}, 32'd0);
      end else begin
        chk("busy", {31'd0, busy}, {31'd0, m_cnt != 0});
        chk("done", {31'd0, done}, {31'd0, m_done});
        if (m_done) begin
          if (sb.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            exp_last = e;
          end
        end
        chk("result_outputs", outs(), {15'd0, exp_last});
      end
    end
  endtask

  // Pulses start with value v and returns at the negedge of the done cycle.
  task automatic do_conv(input int v, output int lat);
    start = 1'b1;
    bin   = 14'(v);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
    chk("conv_done_seen", {31'd0, done}, 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    int lat, lat2, busy_cnt, done_n, ndone, d_first, d_second;
    vecs = '{
      '{1234,  '{4'd1, 4'd2, 4'd3, 4'd4, 1'b0}},
      '{0,     '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0}},
      '{9999,  '{4'd9, 4'd9, 4'd9, 4'd9, 1'b0}},
      '{10000, '{OD, OD, OD, OD, 1'b1}},
      '{16383, '{OD, OD, OD, OD, 1'b1}},
      '{5678,  '{4'd5, 4'd6, 4'd7, 4'd8, 1'b0}},
      '{42,    '{4'd0, 4'd0, 4'd4, 4'd2, 1'b0}},
      '{1000,  '{4'd1, 4'd0, 4'd0, 4'd0, 1'b0}},
      '{9,     '{4'd0, 4'd0, 4'd0, 4'd9, 1'b0}},
      '{10,    '{4'd0, 4'd0, 4'd1, 4'd0, 1'b0}},
      '{809,   '{4'd0, 4'd8, 4'd0, 4'd9, 1'b0}},
      '{5555,  '{4'd5, 4'd5, 4'd5, 4'd5, 1'b0}}
    };
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    #1 chk("reset_state", {outs()[31:1], busy, done}, 32'd0);
    fork
      model();
      monitor();
    join_none
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: busy for 15 cycles, done in cycle 16 after the start cycle.
    start = 1'b1;
    bin   = 14'd1234;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cnt = 0;
    done_n   = 0;
    ndone    = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n <= 15 && busy) busy_cnt++;
      if (done) begin
        ndone++;
        if (done_n == 0) done_n = n;
      end
    end
    chk("latency_busy_cycles", busy_cnt, 15);
    chk("latency_done_cycle", done_n, 16);
    chk("latency_done_count", ndone, 1);
    chk("latency_digits", outs(), {15'd0, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0});

    // Table of vectors.
    foreach (vecs[i]) begin
      do_conv(vecs[i].v, lat);
      chk($sformatf("vec_%0d", vecs[i].v), outs(), {15'd0, vecs[i].e});
    end

    // Back-to-back: second start issued in the done cycle.
    do_conv(0, lat);
    chk("b2b_first", outs(), 32'd0);
    do_conv(9999, lat2);
    chk("b2b_spacing", lat2, 16);
    chk("b2b_second", outs(), {15'd0, 4'd9, 4'd9, 4'd9, 4'd9, 1'b0});

    // Start held 40 cycles; bin scrambled whenever the block is not accepting.
    @(posedge clk);
    #1;
    start    = 1'b1;
    ndone    = 0;
    d_first  = 0;
    d_second = 0;
    for (int k = 0; k < 40; k++) begin
      bin = (k % 16 == 0) ? 14'd42 : 14'($urandom_range(0, 16383));
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (ndone == 1) d_first = k + 1;
        if (ndone == 2) d_second = k + 1;
      end
    end
    start = 1'b0;
    chk("held_done_count", ndone, 2);
    chk("held_done_first", d_first, 16);
    chk("held_done_second", d_second, 32);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("held_third_done", {31'd0, done}, 32'd1);
    chk("held_third_digits", outs(), {15'd0, 4'd0, 4'd0, 4'd4, 4'd2, 1'b0});

    // Reset mid-conversion: abort, no done, then a clean restart.
    do_conv(5678, lat);
    @(posedge clk);
    #1;
    start = 1'b1;
    bin   = 14'd321;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_outputs", {outs()[31:1], busy, done}, 32'd0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_conv(321, lat);
    chk("restart_lat", lat, 16);
    chk("restart_digits", outs(), {15'd0, 4'd0, 4'd3, 4'd2, 4'd1, 1'b0});

    // Sweep of the legal range, strided to stay within the cycle budget.
    for (int v = 0; v <= 9999; v += 7) begin
      do_conv(v, lat);
      chk("sweep", outs(), {15'd0, ref_exp(v)});
    end
    do_conv(9998, lat);
    chk("sweep_9998", outs(), {15'd0, 4'd9, 4'd9, 4'd9, 4'd8, 1'b0});

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
